// File: rtl/adc_seq_csr_responder.sv
// ---------------------------------------------------------------------------
// adc_seq_csr_responder
//
// Avalon-MM CSR responder for the internal ADC sample sequencer. Holds the
// RUN/MODE control register and a status register (current slot, busy flag,
// completed-sequence count). While running, it walks a fixed slot table and
// issues one conversion command per slot to the ADC core over valid/ready.
//
// Ports
//   Clock_qsys       in   1       system clock
//   Reset_n          in   1       asynchronous active-low reset
//   AdcCsrAddress    in   1       0 = CONTROL, 1 = STATUS
//   AdcCsrReadEn     in   1       read strobe
//   AdcCsrReadData   out  32      registered read data (latency 1, held)
//   AdcCsrWriteEn    in   1       write strobe
//   AdcCsrWriteData  in   32      write data
//   CmdValid         out  1       conversion command valid
//   CmdChannel       out  CHAN_W  channel of the current slot
//   CmdSop           out  1       current slot is slot 0
//   CmdEop           out  1       current slot is the last slot
//   CmdReady         in   1       ADC core accepts the command
//   Busy             out  1       sequencer in ISSUE
// ---------------------------------------------------------------------------
module adc_seq_csr_responder #(
  parameter int NUM_SLOTS = 8,
  parameter int CHAN_W    = 5,
  parameter logic [NUM_SLOTS*CHAN_W-1:0] SLOT_CHANNELS =
    {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0},
  parameter int CYC_W     = 16
) (
  input  logic              Clock_qsys,
  input  logic              Reset_n,
  input  logic              AdcCsrAddress,
  input  logic              AdcCsrReadEn,
  output logic [31:0]       AdcCsrReadData,
  input  logic              AdcCsrWriteEn,
  input  logic [31:0]       AdcCsrWriteData,
  output logic              CmdValid,
  output logic [CHAN_W-1:0] CmdChannel,
  output logic              CmdSop,
  output logic              CmdEop,
  input  logic              CmdReady,
  output logic              Busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam int         SLOT_W    = 5;
  localparam int         TBL_DEPTH = 32;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  logic [0:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              run_q, run_d;
  logic              mode_q, mode_d;
  logic              stop_pend_q, stop_pend_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              issuing;
  logic              handshake;
  logic              last_slot;
  logic              wr_ctrl;
  logic              wr_stat;
  logic [31:0]       ctrl_word;
  logic [31:0]       status_word;

  // Only RUN and MODE are implemented in the write data.
  logic unused_wdata;
  assign unused_wdata = ^AdcCsrWriteData[31:2];

  // Slot table padded to the full 5-bit slot index range, so the lookup
  // index width matches the table depth for any legal NUM_SLOTS.
  logic [CHAN_W-1:0] chan_tbl [TBL_DEPTH];

  for (genvar i = 0; i < TBL_DEPTH; i++) begin : g_tbl
    if (i < NUM_SLOTS) begin : g_used
      assign chan_tbl[i] = SLOT_CHANNELS[i*CHAN_W +: CHAN_W];
    end else begin : g_pad
      assign chan_tbl[i] = '0;
    end
  end

  assign issuing   = (state_q == ST_ISSUE);
  assign handshake = issuing && CmdReady;
  assign last_slot = (slot_q == LAST_SLOT);
  assign wr_ctrl   = AdcCsrWriteEn && !AdcCsrAddress;
  assign wr_stat   = AdcCsrWriteEn &&  AdcCsrAddress;

  // Command outputs decode straight from flops, so an asynchronous reset
  // drops CmdValid immediately. Channel/Sop/Eop are gated to read 0 in IDLE.
  assign CmdValid       = issuing;
  assign CmdChannel     = issuing ? chan_tbl[slot_q] : '0;
  assign CmdSop         = issuing && (slot_q == '0);
  assign CmdEop         = issuing && last_slot;
  assign Busy           = issuing;
  assign AdcCsrReadData = rdata_q;

  always_comb begin
    ctrl_word               = '0;
    ctrl_word[0]            = run_q;
    ctrl_word[1]            = mode_q;

    status_word             = '0;
    status_word[4:0]        = slot_q;
    status_word[8]          = issuing;
    status_word[16 +: CYC_W] = cnt_q;
  end

  always_comb begin
    // NOTE: every next-state signal takes its current value first, so no
    // path through the branches below can leave one unassigned (no latches).
    state_d     = state_q;
    slot_d      = slot_q;
    run_d       = run_q;
    mode_d      = mode_q;
    stop_pend_d = stop_pend_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        slot_d = '0;
        if (wr_ctrl) begin
          run_d  = AdcCsrWriteData[0];
          mode_d = AdcCsrWriteData[1];
          if (AdcCsrWriteData[0]) state_d = ST_ISSUE;
        end
      end

      default: begin // ST_ISSUE
        if (wr_ctrl) begin
          run_d       = AdcCsrWriteData[0];
          mode_d      = AdcCsrWriteData[1];
          // RUN=0 lets the current sequence finish; RUN=1 cancels that.
          stop_pend_d = !AdcCsrWriteData[0];
        end

        if (handshake) begin
          if (!last_slot) begin
            slot_d = slot_q + SLOT_W'(1);
          end else begin
            slot_d      = '0;
            stop_pend_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + CYC_W'(1);

            // A CONTROL write in the end cycle overrides the automatic
            // single-sequence clear and the pending stop.
            if (wr_ctrl) begin
              state_d = AdcCsrWriteData[0] ? ST_ISSUE : ST_IDLE;
            end else if (mode_q) begin
              run_d   = 1'b0;
              state_d = ST_IDLE;
            end else if (stop_pend_q) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
    endcase

    // Clear wins over a coinciding increment.
    if (wr_stat) cnt_d = '0;

    // Reads sample the pre-write register values.
    if (AdcCsrReadEn) rdata_d = AdcCsrAddress ? status_word : ctrl_word;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values settled before the clock edge.
  always_ff @(posedge Clock_qsys or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      run_q       <= 1'b0;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      run_q       <= run_d;
      mode_q      <= mode_d;
      stop_pend_q <= stop_pend_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_adc_seq_csr_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_seq_csr_responder
//
// Directed testbench for adc_seq_csr_responder. The main instance uses the
// default 8-slot table; a second instance (1 slot, 4-bit counter) exercises
// the single-slot decode and counter saturation in a short run.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_adc_seq_csr_responder;

  logic        clk;
  logic        rst_n;

  logic        addr, rd_en, wr_en, ready;
  logic [31:0] wdata, rdata;
  logic        cmd_valid, sop, eop, busy;
  logic [4:0]  cmd_channel;

  logic        addr1, rd_en1, wr_en1, ready1;
  logic [31:0] wdata1, rdata1;
  logic        cmd_valid1, sop1, eop1, busy1;
  logic [4:0]  cmd_channel1;

  int checks   = 0;
  int failures = 0;

  adc_seq_csr_responder dut (
    .Clock_qsys      (clk),
    .Reset_n         (rst_n),
    .AdcCsrAddress   (addr),
    .AdcCsrReadEn    (rd_en),
    .AdcCsrReadData  (rdata),
    .AdcCsrWriteEn   (wr_en),
    .AdcCsrWriteData (wdata),
    .CmdValid        (cmd_valid),
    .CmdChannel      (cmd_channel),
    .CmdSop          (sop),
    .CmdEop          (eop),
    .CmdReady        (ready),
    .Busy            (busy)
  );

  adc_seq_csr_responder #(
    .NUM_SLOTS     (1),
    .CHAN_W        (5),
    .SLOT_CHANNELS (5'd9),
    .CYC_W         (4)
  ) dut1 (
    .Clock_qsys      (clk),
    .Reset_n         (rst_n),
    .AdcCsrAddress   (addr1),
    .AdcCsrReadEn    (rd_en1),
    .AdcCsrReadData  (rdata1),
    .AdcCsrWriteEn   (wr_en1),
    .AdcCsrWriteData (wdata1),
    .CmdValid        (cmd_valid1),
    .CmdChannel      (cmd_channel1),
    .CmdSop          (sop1),
    .CmdEop          (eop1),
    .CmdReady        (ready1),
    .Busy            (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    addr = 1'b0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0; ready = 1'b0;
    addr1 = 1'b0; rd_en1 = 1'b0; wr_en1 = 1'b0; wdata1 = '0; ready1 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic csr_write(input logic a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic csr_read(input logic a, output logic [31:0] d);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++;
    if ({cmd_valid, sop, eop, busy, cmd_channel} !== 9'h0) begin
      failures++;
      $display("FAIL reset_cmd: got v=%b sop=%b eop=%b busy=%b ch=%0d want all 0",
               cmd_valid, sop, eop, busy, cmd_channel);
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h want 00000000", rdata);
    end
    csr_read(1'b0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h want 00000000", d); end
    csr_read(1'b1, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_status: got %h want 00000000", d); end
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] d;
    do_reset();
    // Write MODE only (no start) while reading the same register.
    rd_en = 1'b1; wr_en = 1'b1; addr = 1'b0; wdata = 32'hFFFF_FFF2;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL rw_prewrite: got %h want 00000000", rdata); end
    csr_read(1'b0, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL rw_ctrl: got %h want 00000002", d); end
    repeat (3) tick();
    checks++;
    if (rdata !== 32'h2 || cmd_valid !== 1'b0) begin
      failures++; $display("FAIL rw_hold: got rdata=%h v=%b want 00000002 v=0", rdata, cmd_valid);
    end
  endtask

  task automatic test_continuous();
    logic [31:0] d;
    logic [4:0]  c;
    do_reset();
    ready = 1'b1;
    csr_write(1'b0, 32'h1);
    for (int i = 0; i < 16; i++) begin
      c = 5'(i % 8);
      checks++;
      if ({cmd_valid, sop, eop, cmd_channel} !== {1'b1, c == 5'd0, c == 5'd7, c}) begin
        failures++;
        $display("FAIL cont_cmd[%0d]: got v=%b sop=%b eop=%b ch=%0d want v=1 ch=%0d",
                 i, cmd_valid, sop, eop, cmd_channel, c);
      end
      tick();
    end
    csr_read(1'b1, d);
    checks++;
    if (d !== 32'h0002_0100) begin failures++; $display("FAIL cont_status2: got %h want 00020100", d); end
    repeat (7) tick();
    csr_read(1'b1, d);
    checks++;
    if (d !== 32'h0003_0100) begin failures++; $display("FAIL cont_status3: got %h want 00030100", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    int n;
    do_reset();
    ready = 1'b1;
    csr_write(1'b0, 32'h3);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_valid) n++;
      tick();
    end
    checks++;
    if (n != 8) begin failures++; $display("FAIL single_count: got %0d commands want 8", n); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b want 0", busy); end
    csr_read(1'b0, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL single_ctrl: got %h want 00000002", d); end
    csr_read(1'b1, d);
    checks++;
    if (d !== 32'h0001_0000) begin failures++; $display("FAIL single_status: got %h want 00010000", d); end
  endtask

  task automatic test_single_end_write();
    logic [31:0] d;
    int n;
    do_reset();
    ready = 1'b1;
    csr_write(1'b0, 32'h3);
    repeat (7) tick();
    // Rewrite RUN=1 on the last-slot handshake: sequencing restarts at slot 0.
    csr_write(1'b0, 32'h3);
    checks++;
    if ({cmd_valid, sop, cmd_channel} !== {1'b1, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL endwr_restart: got v=%b sop=%b ch=%0d want v=1 sop=1 ch=0",
               cmd_valid, sop, cmd_channel);
    end
    csr_read(1'b0, d);
    checks++;
    if (d !== 32'h3) begin failures++; $display("FAIL endwr_ctrl: got %h want 00000003", d); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (cmd_valid) n++;
      tick();
    end
    checks++;
    if (n != 7) begin failures++; $display("FAIL endwr_tail: got %0d commands want 7", n); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b1;
    csr_write(1'b0, 32'h1);
    repeat (3) tick();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cmd_valid, sop, eop, cmd_channel} !== {1'b1, 1'b0, 1'b0, 5'd3}) begin
        failures++;
        $display("FAIL stall[%0d]: got v=%b sop=%b eop=%b ch=%0d want v=1 ch=3",
                 i, cmd_valid, sop, eop, cmd_channel);
      end
      tick();
    end
    checks++;
    if (cmd_channel !== 5'd3) begin failures++; $display("FAIL stall_hold: got ch=%0d want 3", cmd_channel); end
    ready = 1'b1;
    tick();
    checks++;
    if ({cmd_valid, cmd_channel} !== {1'b1, 5'd4}) begin
      failures++; $display("FAIL stall_release: got v=%b ch=%0d want v=1 ch=4", cmd_valid, cmd_channel);
    end
  endtask

  task automatic test_stop();
    logic [31:0] d;
    do_reset();
    ready = 1'b1;
    csr_write(1'b0, 32'h1);
    repeat (2) tick();
    csr_write(1'b0, 32'h0);  // written while slot 2 is presented
    for (int k = 3; k < 8; k++) begin
      checks++;
      if ({cmd_valid, cmd_channel} !== {1'b1, 5'(k)}) begin
        failures++; $display("FAIL stop_tail[%0d]: got v=%b ch=%0d want v=1 ch=%0d", k, cmd_valid, cmd_channel, k);
      end
      tick();
    end
    checks++;
    if ({cmd_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL stop_idle: got v=%b busy=%b want 0 0", cmd_valid, busy);
    end
    csr_read(1'b1, d);
    checks++;
    if (d !== 32'h0001_0000) begin failures++; $display("FAIL stop_status: got %h want 00010000", d); end

    do_reset();
    ready = 1'b1;
    csr_write(1'b0, 32'h1);
    repeat (2) tick();
    csr_write(1'b0, 32'h0);
    repeat (2) tick();
    csr_write(1'b0, 32'h1);  // cancel the pending stop before slot 7
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({cmd_valid, cmd_channel} !== {1'b1, 5'((6 + i) % 8)}) begin
        failures++;
        $display("FAIL resume[%0d]: got v=%b ch=%0d want v=1 ch=%0d", i, cmd_valid, cmd_channel, (6 + i) % 8);
      end
      tick();
    end
  endtask

  task automatic test_count();
    do_reset();
    ready1 = 1'b1;
    wr_en1 = 1'b1; addr1 = 1'b0; wdata1 = 32'h1;
    tick();
    wr_en1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({cmd_valid1, sop1, eop1, cmd_channel1} !== {1'b1, 1'b1, 1'b1, 5'd9}) begin
        failures++;
        $display("FAIL one_slot[%0d]: got v=%b sop=%b eop=%b ch=%0d want 1 1 1 ch=9",
                 i, cmd_valid1, sop1, eop1, cmd_channel1);
      end
      tick();
    end
    rd_en1 = 1'b1; addr1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    checks++;
    if (rdata1 !== 32'h000F_0100) begin failures++; $display("FAIL sat_status: got %h want 000f0100", rdata1); end
    repeat (5) tick();
    rd_en1 = 1'b1; addr1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    checks++;
    if (rdata1 !== 32'h000F_0100) begin failures++; $display("FAIL sat_hold: got %h want 000f0100", rdata1); end
    wr_en1 = 1'b1; addr1 = 1'b1; wdata1 = 32'h0;
    tick();
    wr_en1 = 1'b0;
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    checks++;
    if (rdata1 !== 32'h0000_0100) begin failures++; $display("FAIL sat_clear: got %h want 00000100", rdata1); end

    // Main instance: clear coinciding with the Eop handshake.
    do_reset();
    ready = 1'b1;
    csr_write(1'b0, 32'h1);
    repeat (7) tick();
    checks++;
    if (eop !== 1'b1) begin failures++; $display("FAIL clr_eop: got eop=%b want 1", eop); end
    csr_write(1'b1, 32'h0);
    rd_en = 1'b1; addr = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rdata !== 32'h0000_0100) begin failures++; $display("FAIL clr_on_eop: got %h want 00000100", rdata); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    ready = 1'b1;
    csr_write(1'b0, 32'h1);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, busy, rdata} !== 34'h0) begin
      failures++; $display("FAIL async_rst: got v=%b busy=%b rdata=%h want all 0", cmd_valid, busy, rdata);
    end
    tick();
    rst_n = 1'b1;
    csr_read(1'b0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL async_ctrl: got %h want 00000000", d); end
    csr_read(1'b1, d);
    checks++;
    if (d !== 32'h0 || cmd_valid !== 1'b0) begin
      failures++; $display("FAIL async_status: got %h v=%b want 00000000 v=0", d, cmd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_rw_same_cycle();
    test_continuous();
    test_single();
    test_single_end_write();
    test_backpressure();
    test_stop();
    test_count();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
